// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run/genlock controls in, raster timing and markers out.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10,
  parameter int FRM_W = 8
);
  logic             en;
  logic             resync;
  logic             p_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             sof;
  logic             sol;
  logic [FRM_W-1:0] frame_cnt;

  modport master (
    input  en, resync,
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, sof, sol, frame_cnt
  );

  modport slave (
    output en, resync,
    input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, sof, sol, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, x/y counters,
// registered sync/blank decode aligned with the counters, frame/line markers,
// frame counter and a genlock restart.
module vga_timing_gen #(
  parameter int H_PX    = 640,
  parameter int H_FP    = 16,
  parameter int H_RT    = 96,
  parameter int H_BP    = 48,
  parameter int V_PX    = 480,
  parameter int V_FP    = 10,
  parameter int V_RT    = 2,
  parameter int V_BP    = 33,
  parameter int CNT_W   = 10,
  parameter int CLK_DIV = 2,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int FRM_W   = 8
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_PX + H_FP + H_RT + H_BP;
  localparam int V_TOTAL = V_PX + V_FP + V_RT + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_PX);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_PX);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_PX + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_PX + H_FP + H_RT - 1);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_PX + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_PX + V_FP + V_RT - 1);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] x_q, y_q, x_nxt, y_nxt;
  logic [FRM_W-1:0] frm_q, frm_nxt;
  logic             von_q, hs_q, vs_q, sof_q, sol_q, resync_q;
  logic             von_nxt, hs_nxt, vs_nxt, sof_nxt, sol_nxt;
  logic             tick, line_end;

  assign tick     = vid.en && (div_cnt == DIV_LAST);
  assign line_end = tick && (x_q == H_LAST);

  // Next divider/counter state; resync wins over en and over any wrap, and
  // a held resync only marks sof/sol on its first cycle.
  always_comb begin
    div_nxt = div_cnt;
    x_nxt   = x_q;
    y_nxt   = y_q;
    frm_nxt = frm_q;
    sof_nxt = 1'b0;
    sol_nxt = 1'b0;
    if (vid.resync) begin
      div_nxt = '0;
      x_nxt   = '0;
      y_nxt   = '0;
      sof_nxt = !resync_q;
      sol_nxt = !resync_q;
    end else if (vid.en) begin
      div_nxt = tick ? '0 : div_cnt + 1'b1;
      if (line_end) begin
        x_nxt   = '0;
        sol_nxt = 1'b1;
        if (y_q == V_LAST) begin
          y_nxt   = '0;
          frm_nxt = frm_q + 1'b1;
          sof_nxt = 1'b1;
        end else begin
          y_nxt = y_q + 1'b1;
        end
      end else if (tick) begin
        x_nxt = x_q + 1'b1;
      end
    end
  end

  // Decode blanking and syncs from the next counter values so the registered
  // levels line up with the coordinates presented in the same cycle.
  always_comb begin
    von_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    hs_nxt  = ((x_nxt >= HS_BEG) && (x_nxt <= HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt  = ((y_nxt >= VS_BEG) && (y_nxt <= VS_END)) ? VS_POL : ~VS_POL;
  end

  // State registers; reset parks the raster at (0,0) with syncs inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      frm_q    <= '0;
      von_q    <= 1'b1;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      sof_q    <= 1'b0;
      sol_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      frm_q    <= frm_nxt;
      von_q    <= von_nxt;
      hs_q     <= hs_nxt;
      vs_q     <= vs_nxt;
      sof_q    <= sof_nxt;
      sol_q    <= sol_nxt;
      resync_q <= vid.resync;
    end
  end

  assign vid.p_tick    = tick;
  assign vid.pixel_x   = x_q;
  assign vid.pixel_y   = y_q;
  assign vid.video_on  = von_q;
  assign vid.hsync     = hs_q;
  assign vid.vsync     = vs_q;
  assign vid.sof       = sof_q && vid.en;
  assign vid.sol       = sol_q && vid.en;
  assign vid.frame_cnt = frm_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on the small 8x6 raster, with a
// CLK_DIV=2 instance and a CLK_DIV=1 instance sharing one stimulus stream.
module tb_vga_timing_gen;

  localparam int HT      = 8;
  localparam int VT      = 6;
  localparam int FRAME   = HT * VT;
  localparam int DIV_A   = 2;
  localparam int DIV_B   = 1;
  localparam int FRM_MOD = 4;

  typedef struct {
    int pos;
    int frames;
    bit sof;
    bit sol;
    bit rs_prev;
  } model_t;

  typedef struct {
    int x;
    int y;
    bit von;
    bit hs;
    bit vs;
    bit tick;
    bit sof;
    bit sol;
    int frm;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  model_t ma, mb;
  exp_t   q_a[$];
  exp_t   q_b[$];

  vga_timing_gen_if #(.CNT_W(10), .FRM_W(2)) vif_a ();
  vga_timing_gen_if #(.CNT_W(10), .FRM_W(2)) vif_b ();

  vga_timing_gen #(
    .H_PX(4), .H_FP(1), .H_RT(2), .H_BP(1),
    .V_PX(3), .V_FP(1), .V_RT(1), .V_BP(1),
    .CNT_W(10), .CLK_DIV(DIV_A), .HS_POL(1'b0), .VS_POL(1'b1), .FRM_W(2)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .vid(vif_a)
  );

  vga_timing_gen #(
    .H_PX(4), .H_FP(1), .H_RT(2), .H_BP(1),
    .V_PX(3), .V_FP(1), .V_RT(1), .V_BP(1),
    .CNT_W(10), .CLK_DIV(DIV_B), .HS_POL(1'b0), .VS_POL(1'b1), .FRM_W(2)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .vid(vif_b)
  );

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the raster is a single clock-phase position within the
  // frame; coordinates and markers are derived from it arithmetically.
  function automatic model_t modelStep(input model_t m, input bit r, input bit e,
                                       input bit rs, input int div);
    model_t n;
    int     nxt;
    n = m;
    if (r) begin
      n.pos = 0; n.frames = 0; n.sof = 0; n.sol = 0; n.rs_prev = 0;
      return n;
    end
    n.sof = 0;
    n.sol = 0;
    if (rs) begin
      n.pos = 0;
      n.sof = !m.rs_prev;
      n.sol = !m.rs_prev;
    end else if (e) begin
      nxt = (m.pos + 1) % (FRAME * div);
      if (m.pos % div == div - 1) begin
        if (nxt == 0) begin
          n.frames = (m.frames + 1) % FRM_MOD;
          n.sof    = 1;
        end
        if ((nxt / div) % HT == 0) n.sol = 1;
      end
      n.pos = nxt;
    end
    n.rs_prev = rs;
    return n;
  endfunction

  function automatic int mx(input model_t m, input int div);
    return (m.pos / div) % HT;
  endfunction

  function automatic int my(input model_t m, input int div);
    return m.pos / (div * HT);
  endfunction

  function automatic exp_t predict(input model_t m, input bit e, input int div);
    exp_t p;
    p.x    = mx(m, div);
    p.y    = my(m, div);
    p.von  = (p.x < 4) && (p.y < 3);
    p.hs   = !((p.x >= 5) && (p.x <= 6));
    p.vs   = (p.y == 4);
    p.tick = e && (m.pos % div == div - 1);
    p.sof  = m.sof && e;
    p.sol  = m.sol && e;
    p.frm  = m.frames;
    return p;
  endfunction

  // Drive one cycle of inputs and queue what both DUTs must show after the edge
  task automatic applyStimulus(input bit r, input bit e, input bit rs);
    @(negedge clk);
    rst          = r;
    vif_a.en     = e;
    vif_a.resync = rs;
    vif_b.en     = e;
    vif_b.resync = rs;
    ma = modelStep(ma, r, e, rs, DIV_A);
    mb = modelStep(mb, r, e, rs, DIV_B);
    q_a.push_back(predict(ma, e, DIV_A));
    q_b.push_back(predict(mb, e, DIV_B));
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e,
                             input logic [9:0] x, input logic [9:0] y,
                             input logic von, input logic hs, input logic vs,
                             input logic tick, input logic sof, input logic sol,
                             input logic [1:0] frm);
    cmp({tag, ".pixel_x"},   32'(x),    32'(e.x));
    cmp({tag, ".pixel_y"},   32'(y),    32'(e.y));
    cmp({tag, ".video_on"},  32'(von),  32'(e.von));
    cmp({tag, ".hsync"},     32'(hs),   32'(e.hs));
    cmp({tag, ".vsync"},     32'(vs),   32'(e.vs));
    cmp({tag, ".p_tick"},    32'(tick), 32'(e.tick));
    cmp({tag, ".sof"},       32'(sof),  32'(e.sof));
    cmp({tag, ".sol"},       32'(sol),  32'(e.sol));
    cmp({tag, ".frame_cnt"}, 32'(frm),  32'(e.frm));
  endtask

  // Monitor: after every active edge, pop the queued expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        checkOutput("a", e, vif_a.pixel_x, vif_a.pixel_y, vif_a.video_on, vif_a.hsync,
                    vif_a.vsync, vif_a.p_tick, vif_a.sof, vif_a.sol, vif_a.frame_cnt);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        checkOutput("b", e, vif_b.pixel_x, vif_b.pixel_y, vif_b.video_on, vif_b.hsync,
                    vif_b.vsync, vif_b.p_tick, vif_b.sof, vif_b.sol, vif_b.frame_cnt);
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int r;
    checks       = 0;
    failures     = 0;
    ma           = '{default: 0};
    mb           = '{default: 0};
    rst          = 1'b1;
    vif_a.en     = 1'b1;
    vif_a.resync = 1'b0;
    vif_b.en     = 1'b1;
    vif_b.resync = 1'b0;

    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (4 * FRAME * DIV_A + 10) applyStimulus(0, 1, 0);

    for (int i = 0; i < 100 && mx(ma, DIV_A) != 6; i++) applyStimulus(0, 1, 0);
    repeat (7) applyStimulus(0, 0, 0);
    repeat (40) applyStimulus(0, 1, 0);

    for (int i = 0; i < 200 && !(mx(ma, DIV_A) == 3 && my(ma, DIV_A) == 2); i++)
      applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    repeat (20) applyStimulus(0, 1, 0);

    for (int i = 0; i < 200 && ma.pos != FRAME * DIV_A - 1; i++) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    repeat (10) applyStimulus(0, 1, 0);

    repeat (5) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    repeat (10) applyStimulus(0, 1, 0);

    repeat (5) applyStimulus(0, 1, 1);
    repeat (10) applyStimulus(0, 1, 0);

    for (int i = 0; i < 200 && !(mx(ma, DIV_A) == 6 && my(ma, DIV_A) == 4); i++)
      applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (20) applyStimulus(0, 1, 0);

    repeat (3000) begin
      r = int'($urandom_range(0, 199));
      applyStimulus(r == 0, $urandom_range(0, 9) != 0, (r >= 1) && (r <= 4));
    end
    repeat (5) applyStimulus(0, 1, 0);

    @(posedge clk);
    #2;
    cmp("queue_a_drained", 32'(q_a.size()), 32'd0);
    cmp("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
